// File: rtl/sfx_sequencer_if.sv
// rtl/sfx_sequencer_if.sv - sound_t package and event/sound interface for sfx_sequencer (POWER_LOOP_EN adds power_end)
package sfx_pkg;
   typedef enum logic [2:0] {
      SOUND_NONE  = 3'd0,
      SOUND_CHOMP = 3'd1,
      SOUND_POWER = 3'd2,
      SOUND_DEATH = 3'd3,
      SOUND_START = 3'd4
   } sound_t;
endpackage

interface sfx_sequencer_if #(parameter int IDX_W = 16);
   import sfx_pkg::*;

   logic             ev_chomp;
   logic             ev_power;
   logic             ev_death;
   logic             ev_start;
   logic             mute;
`ifdef POWER_LOOP_EN
   logic             power_end;
`endif
   sound_t           sound_type;
   logic             clk_8KHZ;
   logic [IDX_W-1:0] sample_idx;
   logic             busy;
   logic             pending;

   // Game logic side: raises event pulses, watches the selection.
   modport master (
      output ev_chomp, output ev_power, output ev_death, output ev_start, output mute,
`ifdef POWER_LOOP_EN
      output power_end,
`endif
      input  sound_type, input clk_8KHZ, input sample_idx, input busy, input pending
   );

   // Sequencer side.
   modport slave (
      input  ev_chomp, input ev_power, input ev_death, input ev_start, input mute,
`ifdef POWER_LOOP_EN
      input  power_end,
`endif
      output sound_type, output clk_8KHZ, output sample_idx, output busy, output pending
   );
endinterface

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - prioritised sound selection, 8 kHz sample strobe and index tracking (optional POWER_LOOP_EN)
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int CLK_DIV   = 3125,
   parameter int CHOMP_LEN = 5736,
   parameter int POWER_LEN = 8000,
   parameter int DEATH_LEN = 12000,
   parameter int START_LEN = 33000,
   parameter int IDX_W     = 16
) (
   input logic          clk_25MHZ,
   input logic          rst_n,
   sfx_sequencer_if.slave bus
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic {ST_IDLE, ST_PLAY} state_t;

   logic [DIV_W-1:0] r_div;
   logic             r_strobe;
   state_t           r_state;
   sound_t           r_sound;
   sound_t           r_pend;
   logic             r_pend_v;
   logic [IDX_W-1:0] r_idx;
   logic             r_busy;

   sound_t           w_ev;
   sound_t           w_pend_nxt;
   logic [IDX_W-1:0] w_last;
   logic             w_end;
   logic             w_loop;

   // Highest-priority event this cycle; the enum values are ordered by priority.
   always_comb begin
      w_ev = SOUND_NONE;
      if (bus.ev_start)      w_ev = SOUND_START;
      else if (bus.ev_death) w_ev = SOUND_DEATH;
      else if (bus.ev_power) w_ev = SOUND_POWER;
      else if (bus.ev_chomp) w_ev = SOUND_CHOMP;
   end

   // Index of the final sample of the playing sound.
   always_comb begin
      w_last = '0;
      case (r_sound)
         SOUND_CHOMP: w_last = IDX_W'(CHOMP_LEN - 1);
         SOUND_POWER: w_last = IDX_W'(POWER_LEN - 1);
         SOUND_DEATH: w_last = IDX_W'(DEATH_LEN - 1);
         SOUND_START: w_last = IDX_W'(START_LEN - 1);
         default:     w_last = '0;
      endcase
   end

   assign w_end = (r_state == ST_PLAY) && r_strobe && (r_idx == w_last);

   // A lower-priority event may take the slot when it outranks what is queued
   // (an empty slot holds SOUND_NONE, which everything outranks); DEATH never queues anything below itself.
   assign w_pend_nxt = ((w_ev != SOUND_NONE) && (w_ev < r_sound) &&
                        (r_sound != SOUND_DEATH) && (w_ev > r_pend)) ? w_ev : r_pend;

`ifdef POWER_LOOP_EN
   logic r_power_stop;

   // Sticky stop request for the power loop, dropped once POWER leaves or wraps.
   always_ff @(posedge clk_25MHZ) begin
      if (!rst_n)
         r_power_stop <= 1'b0;
      else if ((r_state == ST_PLAY) && (r_sound == SOUND_POWER) && !w_end)
         r_power_stop <= r_power_stop | bus.power_end;
      else
         r_power_stop <= 1'b0;
   end

   assign w_loop = (r_sound == SOUND_POWER) && !(r_power_stop || bus.power_end);
`else
   assign w_loop = 1'b0;
`endif

   // Free-running divider producing the one-cycle sample strobe.
   always_ff @(posedge clk_25MHZ) begin
      if (!rst_n) begin
         r_div    <= '0;
         r_strobe <= 1'b0;
      end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
         r_div    <= '0;
         r_strobe <= 1'b1;
      end else begin
         r_div    <= r_div + DIV_W'(1);
         r_strobe <= 1'b0;
      end
   end

   // Sequencer: preemption/restart/queueing decided before end-of-sound handling.
   always_ff @(posedge clk_25MHZ) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sound  <= SOUND_NONE;
         r_pend   <= SOUND_NONE;
         r_pend_v <= 1'b0;
         r_idx    <= '0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_ev != SOUND_NONE) begin
                  r_state <= ST_PLAY;
                  r_busy  <= 1'b1;
                  r_sound <= w_ev;
                  r_idx   <= '0;
               end
            end
            ST_PLAY: begin
               if (w_ev > r_sound) begin
                  r_sound <= w_ev;
                  r_idx   <= '0;
                  if (w_ev == SOUND_DEATH) begin
                     r_pend   <= SOUND_NONE;
                     r_pend_v <= 1'b0;
                  end
               end else if (w_ev == r_sound) begin
                  r_idx <= '0;
               end else if (w_end && w_loop) begin
                  r_idx    <= '0;
                  r_pend   <= w_pend_nxt;
                  r_pend_v <= (w_pend_nxt != SOUND_NONE);
               end else if (w_end && (w_pend_nxt != SOUND_NONE)) begin
                  r_sound  <= w_pend_nxt;
                  r_idx    <= '0;
                  r_pend   <= SOUND_NONE;
                  r_pend_v <= 1'b0;
               end else if (w_end) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_sound <= SOUND_NONE;
                  r_idx   <= '0;
               end else begin
                  if (r_strobe) r_idx <= r_idx + IDX_W'(1);
                  r_pend   <= w_pend_nxt;
                  r_pend_v <= (w_pend_nxt != SOUND_NONE);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.sound_type = bus.mute ? SOUND_NONE : r_sound;
   assign bus.clk_8KHZ   = r_strobe;
   assign bus.sample_idx = r_idx;
   assign bus.busy       = r_busy;
   assign bus.pending    = r_pend_v;

endmodule
